bk_pipelined_subtractor: RTL

// - Pipelined unsigned subtractor D = X - Y. Uses the same Brent-Kung prefix carry network
//   as the team's combinational adders: computes X + ~Y + 1 with Cin tied to 1.
// - Split into 3 registered stages with a valid/ready handshake.
// - Sits between operand producers and consumers in datapaths that need registered difference/borrow.

---
 rtl/bk_pipelined_subtractor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bk_pipelined_subtractor.sv
// Three-stage pipelined unsigned subtractor D = X - Y built on a Brent-Kung prefix network
// (X + ~Y + 1) with valid/ready flow control. Define BKS_SATURATE_EN for a floor-at-zero D.
module bk_pipelined_subtractor #(
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D,
  output logic             BORROW
);

  localparam int LEVELS = $clog2(WIDTH);

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic adv1, adv2, adv3;

  logic [WIDTH-1:0] g1_q, g1_d, p1_q, p1_d;
  logic [WIDTH-1:0] g2_q, g2_d, p2_q, p2_d, pb2_q, pb2_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;

  logic [WIDTH-1:0] up_g, up_p, dn_g, dn_p, sum;
  logic [WIDTH:0]   carry;

  // A stage may take new contents when it is empty or its contents move on.
  always_comb begin
    adv3     = ~v3_q | OUT_READY;
    adv2     = ~v2_q | adv3;
    adv1     = ~v1_q | adv2;
    IN_READY = adv1;
    v1_d     = adv1 ? IN_VALID : v1_q;
    v2_d     = adv2 ? v1_q     : v2_q;
    v3_d     = adv3 ? v2_q     : v3_q;
  end

  // S1: per-bit generate/propagate of X + ~Y.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    g1_d = g1_q;
    p1_d = p1_q;
    if (adv1 && IN_VALID) begin
      g1_d = X & ~Y;
      p1_d = X ^ ~Y;
    end
  end

  // S2: up-sweep; node j at level l spans bits [j : j-2^l+1].
  always_comb begin
    up_g = g1_q;
    up_p = p1_q;
    for (int l = 1; l <= LEVELS; l++) begin
      for (int j = (1 << l) - 1; j < WIDTH; j += (1 << l)) begin
        up_g[j] = up_g[j] | (up_p[j] & up_g[j - (1 << (l - 1))]);
        up_p[j] = up_p[j] & up_p[j - (1 << (l - 1))];
      end
    end
    g2_d  = g2_q;
    p2_d  = p2_q;
    pb2_d = pb2_q;
    if (adv2 && v1_q) begin
      g2_d  = up_g;
      p2_d  = up_p;
      pb2_d = p1_q;
    end
  end

  // S3: down-sweep fills the remaining prefixes, then carry-in of 1 is folded in.
  always_comb begin
    dn_g = g2_q;
    dn_p = p2_q;
    for (int l = LEVELS; l >= 1; l--) begin
      for (int j = (1 << l) + (1 << (l - 1)) - 1; j < WIDTH; j += (1 << l)) begin
        dn_g[j] = dn_g[j] | (dn_p[j] & dn_g[j - (1 << (l - 1))]);
        dn_p[j] = dn_p[j] & dn_p[j - (1 << (l - 1))];
      end
    end
    carry[0] = 1'b1;
    for (int i = 1; i <= WIDTH; i++) begin
      carry[i] = dn_g[i-1] | dn_p[i-1];
    end
    sum      = carry[WIDTH-1:0] ^ pb2_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    if (adv3 && v2_q) begin
      borrow_d = ~carry[WIDTH];
`ifdef BKS_SATURATE_EN
      d_d      = carry[WIDTH] ? sum : '0;
`else
      d_d      = sum;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
    end
  end

  // NOTE: internal operand registers are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge CLK) begin
    g1_q  <= g1_d;
    p1_q  <= p1_d;
    g2_q  <= g2_d;
    p2_q  <= p2_d;
    pb2_q <= pb2_d;
  end

  assign OUT_VALID = v3_q;
  assign D         = d_q;
  assign BORROW    = borrow_q;

endmodule
